// File: rtl/obi_dmem_arbiter_if.sv
// ============================================================================
// Module : obi_dmem_arbiter_if
// Brief  : One OBI data link with DIFT tag sideband (master/slave views).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface obi_dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
);
  logic                  req;
  logic                  gnt;
  logic                  rvalid;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  we_tag;
  logic [TAG_WIDTH-1:0]  wdata_tag;
  logic [TAG_WIDTH-1:0]  rdata_tag;

  modport master (
    output req, addr, we, be, wdata, we_tag, wdata_tag,
    input  gnt, rvalid, rdata, rdata_tag
  );

  modport slave (
    input  req, addr, we, be, wdata, we_tag, wdata_tag,
    output gnt, rvalid, rdata, rdata_tag
  );
endinterface

`default_nettype wire

// File: rtl/obi_dmem_arbiter.sv
// ============================================================================
// Module : obi_dmem_arbiter
// Brief  : Two-master round-robin OBI arbiter for data RAM + DIFT tag memory,
//          with an owner FIFO routing responses. Option: OBI_ARB_DIFT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module obi_dmem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int TAG_WIDTH       = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  obi_dmem_arbiter_if.slave      m0,
  obi_dmem_arbiter_if.slave      m1,
  obi_dmem_arbiter_if.master     s,
  output logic                   err_o
);

  localparam int c_PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int c_CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_PW-1:0] c_PTR_LAST = c_PW'(MAX_OUTSTANDING - 1);
  localparam logic [c_CW-1:0] c_FULL     = c_CW'(MAX_OUTSTANDING);

  logic [MAX_OUTSTANDING-1:0] r_owner;
  logic [c_PW-1:0]            r_wptr;
  logic [c_PW-1:0]            r_rptr;
  logic [c_CW-1:0]            r_count;
  logic                       r_rr_last;
  logic                       r_err;

  logic w_sel;
  logic w_full;
  logic w_xfer;
  logic w_pop;
  logic w_head;

  always_comb begin
    w_sel = 1'b0;
    if (m0.req && m1.req) begin
      w_sel = ~r_rr_last;
    end else if (m1.req) begin
      w_sel = 1'b1;
    end
  end

  assign w_full = (r_count == c_FULL);
  assign w_xfer = s.req && s.gnt;
  // A response with nothing outstanding is flagged, never routed.
  assign w_pop  = s.rvalid && (r_count != '0);
  assign w_head = r_owner[r_rptr];

  assign s.req   = (m0.req || m1.req) && !w_full;
  assign s.addr  = w_sel ? m1.addr  : m0.addr;
  assign s.we    = w_sel ? m1.we    : m0.we;
  assign s.be    = w_sel ? m1.be    : m0.be;
  assign s.wdata = w_sel ? m1.wdata : m0.wdata;

  assign m0.gnt    = w_xfer && !w_sel;
  assign m1.gnt    = w_xfer &&  w_sel;
  assign m0.rvalid = w_pop && !w_head;
  assign m1.rvalid = w_pop &&  w_head;
  assign m0.rdata  = s.rdata;
  assign m1.rdata  = s.rdata;

`ifdef OBI_ARB_DIFT_EN
  assign s.we_tag       = w_sel ? m1.we_tag    : m0.we_tag;
  assign s.wdata_tag    = w_sel ? m1.wdata_tag : m0.wdata_tag;
  assign m0.rdata_tag   = s.rdata_tag;
  assign m1.rdata_tag   = s.rdata_tag;
`else
  logic w_unused_tag;
  assign w_unused_tag   = ^{m0.we_tag, m0.wdata_tag, m1.we_tag, m1.wdata_tag, s.rdata_tag};
  assign s.we_tag       = 1'b0;
  assign s.wdata_tag    = '0;
  assign m0.rdata_tag   = '0;
  assign m1.rdata_tag   = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_rr_last <= 1'b1;
      r_err     <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_owner[r_wptr] <= w_sel;
        r_wptr          <= (r_wptr == c_PTR_LAST) ? '0 : r_wptr + 1'b1;
        r_rr_last       <= w_sel;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == c_PTR_LAST) ? '0 : r_rptr + 1'b1;
      end
      case ({w_xfer, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (s.rvalid && (r_count == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err_o = r_err;

endmodule

`default_nettype wire

// File: tb/tb_obi_dmem_arbiter.sv
// ============================================================================
// Module : tb_obi_dmem_arbiter
// Brief  : Directed + randomized self-checking bench for obi_dmem_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_obi_dmem_arbiter;

  localparam int ADDR_WIDTH      = 32;
  localparam int TAG_WIDTH       = 4;
  localparam int MAX_OUTSTANDING = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_o;

  obi_dmem_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH), .TAG_WIDTH(TAG_WIDTH)) m0_if ();
  obi_dmem_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH), .TAG_WIDTH(TAG_WIDTH)) m1_if ();
  obi_dmem_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH), .TAG_WIDTH(TAG_WIDTH)) s_if ();

  obi_dmem_arbiter #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .TAG_WIDTH       (TAG_WIDTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if),
    .err_o (err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: issue-order queue of owners, last granted master, sticky error.
  int owners[$];
  int last_gnt = 1;
  bit m_err = 1'b0;
  bit g0, g1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owners.delete();
    last_gnt = 1;
    m_err    = 1'b0;
  endtask

  task automatic idle();
    m0_if.req = 0; m0_if.addr = '0; m0_if.we = 0; m0_if.be = '0; m0_if.wdata = '0;
    m0_if.we_tag = 0; m0_if.wdata_tag = '0;
    m1_if.req = 0; m1_if.addr = '0; m1_if.we = 0; m1_if.be = '0; m1_if.wdata = '0;
    m1_if.we_tag = 0; m1_if.wdata_tag = '0;
    s_if.gnt = 0; s_if.rvalid = 0; s_if.rdata = '0; s_if.rdata_tag = '0;
  endtask

  // Called mid-cycle: compare DUT against the model, then advance both one edge.
  task automatic tick();
    int  sel;
    bit  exp_req, xfer, rv0, rv1;
    logic [31:0] e_addr, e_wdata;
    logic        e_we, e_wt;
    logic [3:0]  e_be, e_tag;
    sel = (m0_if.req && m1_if.req) ? (last_gnt == 0 ? 1 : 0) : (m1_if.req ? 1 : 0);
    exp_req = (m0_if.req || m1_if.req) && (owners.size() < MAX_OUTSTANDING);
    xfer = exp_req && s_if.gnt;
    check("s_req", 32'(s_if.req), 32'(exp_req));
    check("m0_gnt", 32'(m0_if.gnt), 32'(xfer && sel == 0));
    check("m1_gnt", 32'(m1_if.gnt), 32'(xfer && sel == 1));
    if (exp_req) begin
      e_addr  = sel ? m1_if.addr  : m0_if.addr;
      e_we    = sel ? m1_if.we    : m0_if.we;
      e_be    = sel ? m1_if.be    : m0_if.be;
      e_wdata = sel ? m1_if.wdata : m0_if.wdata;
`ifdef OBI_ARB_DIFT_EN
      e_wt    = sel ? m1_if.we_tag    : m0_if.we_tag;
      e_tag   = sel ? m1_if.wdata_tag : m0_if.wdata_tag;
`else
      e_wt    = 1'b0;
      e_tag   = 4'h0;
`endif
      check("s_addr", s_if.addr, e_addr);
      check("s_we", 32'(s_if.we), 32'(e_we));
      check("s_be", 32'(s_if.be), 32'(e_be));
      check("s_wdata", s_if.wdata, e_wdata);
      check("s_we_tag", 32'(s_if.we_tag), 32'(e_wt));
      check("s_wdata_tag", 32'(s_if.wdata_tag), 32'(e_tag));
    end
    rv0 = s_if.rvalid && owners.size() > 0 && owners[0] == 0;
    rv1 = s_if.rvalid && owners.size() > 0 && owners[0] == 1;
    check("m0_rvalid", 32'(m0_if.rvalid), 32'(rv0));
    check("m1_rvalid", 32'(m1_if.rvalid), 32'(rv1));
    if (rv0 || rv1) begin
      check("rdata", rv0 ? m0_if.rdata : m1_if.rdata, s_if.rdata);
`ifdef OBI_ARB_DIFT_EN
      check("rdata_tag", 32'(rv0 ? m0_if.rdata_tag : m1_if.rdata_tag), 32'(s_if.rdata_tag));
`else
      check("rdata_tag", 32'(rv0 ? m0_if.rdata_tag : m1_if.rdata_tag), 32'd0);
`endif
    end
    check("err", 32'(err_o), 32'(m_err));
    if (s_if.rvalid) begin
      if (owners.size() > 0) void'(owners.pop_front());
      else m_err = 1'b1;
    end
    if (xfer) begin
      owners.push_back(sel);
      last_gnt = sel;
    end
    g0 = xfer && sel == 0;
    g1 = xfer && sel == 1;
    @(posedge clk);
    #1;
  endtask

  int ng;

  initial begin
    idle();
    #3;
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_sreq", 32'(s_if.req), 32'd0);
    check("rst_rvalid", 32'({m0_if.rvalid, m1_if.rvalid}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Reset priority: simultaneous reads, m0 wins first tie.
    m0_if.req = 1; m0_if.addr = 32'h100;
    m1_if.req = 1; m1_if.addr = 32'h200;
    s_if.gnt = 1;
    @(negedge clk);
    check("prio_m0_gnt", 32'(m0_if.gnt), 32'd1);
    tick();
    m0_if.req = 0;
    s_if.rvalid = 1; s_if.rdata = 32'hAAAA0000;
    @(negedge clk);
    check("prio_m1_gnt", 32'(m1_if.gnt), 32'd1);
    check("prio_m0_rv", 32'(m0_if.rvalid), 32'd1);
    check("prio_m0_rdata", m0_if.rdata, 32'hAAAA0000);
    tick();
    m1_if.req = 0;
    s_if.rdata = 32'hBBBB0000;
    @(negedge clk);
    check("prio_m1_rv", 32'(m1_if.rvalid), 32'd1);
    check("prio_m1_rdata", m1_if.rdata, 32'hBBBB0000);
    tick();

    // Continuous contention: strict alternation starting with m0.
    for (int k = 0; k < 6; k++) begin
      m0_if.req = 1; m0_if.addr = 32'h1000 + 32'(k);
      m1_if.req = 1; m1_if.addr = 32'h2000 + 32'(k);
      s_if.gnt = 1;
      s_if.rvalid = owners.size() > 0;
      s_if.rdata = $urandom;
      @(negedge clk);
      check("alt_m0_gnt", 32'(m0_if.gnt), 32'(k % 2 == 0));
      check("alt_m1_gnt", 32'(m1_if.gnt), 32'(k % 2 == 1));
      tick();
    end
    idle();
    s_if.rvalid = 1;
    @(negedge clk);
    tick();

    // Tag write path from m1.
    idle();
    m1_if.req = 1; m1_if.we = 1; m1_if.be = 4'b0011; m1_if.wdata = 32'hDEADBEEF;
    m1_if.we_tag = 1; m1_if.wdata_tag = 4'h5; m1_if.addr = 32'h300;
    s_if.gnt = 1;
    @(negedge clk);
    check("tag_be", 32'(s_if.be), 32'b0011);
    check("tag_wdata", s_if.wdata, 32'hDEADBEEF);
`ifdef OBI_ARB_DIFT_EN
    check("tag_wdata_tag", 32'(s_if.wdata_tag), 32'h5);
`else
    check("tag_wdata_tag", 32'(s_if.wdata_tag), 32'h0);
`endif
    tick();
    idle();
    s_if.rvalid = 1;
    @(negedge clk);
    check("tag_wr_rv", 32'(m1_if.rvalid), 32'd1);
    tick();

    // Spurious response: sticky error, nothing routed.
    idle();
    s_if.rvalid = 1;
    @(negedge clk);
    check("spur_rv", 32'({m0_if.rvalid, m1_if.rvalid}), 32'd0);
    tick();
    idle();
    @(negedge clk);
    check("spur_err", 32'(err_o), 32'd1);
    tick();
    @(negedge clk);
    tick();

    // Two outstanding, then asynchronous reset mid-burst.
    m0_if.req = 1; m0_if.addr = 32'h400; s_if.gnt = 1;
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("arst_err", 32'(err_o), 32'd0);
    check("arst_sreq", 32'(s_if.req), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Full FIFO: fresh count admits exactly MAX_OUTSTANDING grants.
    m0_if.req = 1; m0_if.addr = 32'h500; s_if.gnt = 1;
    ng = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ng += int'(m0_if.gnt);
      tick();
    end
    check("full_grants", 32'(ng), 32'(MAX_OUTSTANDING));
    @(negedge clk);
    check("full_sreq", 32'(s_if.req), 32'd0);
    tick();
    s_if.rvalid = 1;
    @(negedge clk);
    tick();
    s_if.rvalid = 0;
    ng = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ng += int'(m0_if.gnt);
      tick();
    end
    check("refill_grants", 32'(ng), 32'd1);
    idle();
    while (owners.size() > 0) begin
      s_if.rvalid = 1;
      @(negedge clk);
      tick();
    end

    // Randomized traffic; masters hold requests until granted.
    idle();
    g0 = 0; g1 = 0;
    for (int n = 0; n < 400; n++) begin
      if (g0 || !m0_if.req) begin
        m0_if.req = 1'($urandom_range(0, 1)); m0_if.addr = $urandom; m0_if.we = 1'($urandom);
        m0_if.be = 4'($urandom); m0_if.wdata = $urandom;
        m0_if.we_tag = 1'($urandom); m0_if.wdata_tag = 4'($urandom);
      end
      if (g1 || !m1_if.req) begin
        m1_if.req = 1'($urandom_range(0, 1)); m1_if.addr = $urandom; m1_if.we = 1'($urandom);
        m1_if.be = 4'($urandom); m1_if.wdata = $urandom;
        m1_if.we_tag = 1'($urandom); m1_if.wdata_tag = 4'($urandom);
      end
      s_if.gnt = ($urandom_range(0, 3) != 0);
      s_if.rvalid = (owners.size() > 0) && ($urandom_range(0, 2) != 0);
      s_if.rdata = $urandom;
      s_if.rdata_tag = 4'($urandom);
      @(negedge clk);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
